// File: rtl/tx_rd_req_scheduler.sv
// TX read-request scheduler: turns 512 B chunk read requests into a series of
// MRRS-sized PCIe memory-read TLPs on the TRN transmit interface, drawing one
// tag per TLP from a bitmap pool that the completion side releases.
module tx_rd_req_scheduler #(
    parameter int TAG_W    = 3,
    parameter int MRRS_QW  = 16,
    parameter int CHUNK_QW = 64
) (
    input  logic              trn_clk,
    input  logic              reset,
    input  logic [15:0]       cfg_completer_id,
    input  logic [63:0]       huge_page_addr_read_from,
    input  logic              read_chunk,
    output logic              read_chunk_ack,
    output logic [63:0]       trn_td,
    output logic [7:0]        trn_trem_n,
    output logic              trn_tsof_n,
    output logic              trn_teof_n,
    output logic              trn_tsrc_rdy_n,
    input  logic              trn_tdst_rdy_n,
    input  logic              cpl_done,
    input  logic [TAG_W-1:0]  cpl_done_tag,
    output logic [TAG_W:0]    tags_outstanding,
    output logic              busy,
    output logic              err_tag_free
);

    localparam int          NTAGS     = 1 << TAG_W;
    localparam int          TLPS      = CHUNK_QW / MRRS_QW;
    localparam int          REM_W     = $clog2(TLPS + 1);
    // Length field is 10 bits; a full 1024 DW request wraps to 0 as PCIe expects.
    localparam logic [9:0]  LEN_DW    = 10'(MRRS_QW * 2);
    localparam logic [63:0] ADDR_STEP = 64'(MRRS_QW * 8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_TAG,
        S_HDR0,
        S_HDR1,
        S_NEXT
    } state_t;

    state_t             state_q, state_d;
    logic [63:0]        addr_q, addr_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [TAG_W-1:0]   cur_tag_q, cur_tag_d;
    logic               ack_q, ack_d;
    logic               busy_q, busy_d;
    logic [NTAGS-1:0]   bitmap_q, bitmap_d;
    logic [TAG_W:0]     tags_q, tags_d;
    logic               err_q, err_d;

    logic               free_found;
    logic [TAG_W-1:0]   free_idx;
    logic               alloc;
    logic [31:0]        dw0;
    logic               addr_is_64;

    // Lowest-index free tag in the pool (descending scan so the lowest wins).
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NTAGS - 1; i >= 0; i--) begin
            if (!bitmap_q[i]) begin
                free_found = 1'b1;
                free_idx   = TAG_W'(i);
            end
        end
    end

    // State register and all datapath flops.
    always_ff @(posedge trn_clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            cur_tag_q <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            bitmap_q  <= '0;
            tags_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            cur_tag_q <= cur_tag_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            bitmap_q  <= bitmap_d;
            tags_q    <= tags_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic: chunk acceptance, tag allocation, TLP sequencing.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        cur_tag_d = cur_tag_q;
        ack_d     = 1'b0;
        busy_d    = busy_q;
        alloc     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (read_chunk) begin
                    ack_d   = 1'b1;
                    addr_d  = huge_page_addr_read_from;
                    rem_d   = REM_W'(TLPS);
                    busy_d  = 1'b1;
                    state_d = S_GET_TAG;
                end
            end
            S_GET_TAG: begin
                if (free_found) begin
                    alloc     = 1'b1;
                    cur_tag_d = free_idx;
                    state_d   = S_HDR0;
                end
            end
            S_HDR0: begin
                if (!trn_tdst_rdy_n) begin
                    state_d = S_HDR1;
                end
            end
            S_HDR1: begin
                if (!trn_tdst_rdy_n) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                addr_d = addr_q + ADDR_STEP;
                rem_d  = rem_q - REM_W'(1);
                if (rem_q == REM_W'(1)) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_GET_TAG;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Tag pool: set on allocation, clear on a valid release, flag bogus
    // releases. Allocation only ever picks a clear bit and a valid release
    // only touches a set bit, so the two can never collide on one tag.
    always_comb begin
        bitmap_d = bitmap_q;
        err_d    = err_q;
        if (alloc) begin
            bitmap_d[free_idx] = 1'b1;
        end
        if (cpl_done) begin
            if (bitmap_q[cpl_done_tag]) begin
                bitmap_d[cpl_done_tag] = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
        tags_d = '0;
        for (int i = 0; i < NTAGS; i++) begin
            tags_d = tags_d + (TAG_W + 1)'(bitmap_d[i]);
        end
    end

    // Header DW0: memory read, 3DW or 4DW depending on the upper address.
    always_comb begin
        addr_is_64 = |addr_q[63:32];
        dw0        = {1'b0, (addr_is_64 ? 2'b01 : 2'b00), 5'b00000,
                      1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, LEN_DW};
    end

    // Output logic: TRN beat contents purely from the current state.
    always_comb begin
        trn_td         = '0;
        trn_trem_n     = 8'h00;
        trn_tsof_n     = 1'b1;
        trn_teof_n     = 1'b1;
        trn_tsrc_rdy_n = 1'b1;
        case (state_q)
            S_HDR0: begin
                trn_tsrc_rdy_n = 1'b0;
                trn_tsof_n     = 1'b0;
                trn_td         = {dw0, cfg_completer_id, 8'(cur_tag_q), 4'hF, 4'hF};
            end
            S_HDR1: begin
                trn_tsrc_rdy_n = 1'b0;
                trn_teof_n     = 1'b0;
                if (addr_is_64) begin
                    trn_td     = {addr_q[63:32], addr_q[31:2], 2'b00};
                    trn_trem_n = 8'h00;
                end else begin
                    trn_td     = {addr_q[31:2], 2'b00, 32'h0};
                    trn_trem_n = 8'h0F;
                end
            end
            default: ;
        endcase
    end

    assign read_chunk_ack   = ack_q;
    assign busy             = busy_q;
    assign tags_outstanding = tags_q;
    assign err_tag_free     = err_q;

endmodule

// File: doc/tx_rd_req_scheduler.md
Name: tx_rd_req_scheduler

Overview:
Sequences host-memory reads for the TX path. It accepts 512-byte chunk read requests from the huge-page consumer over the read_chunk/read_chunk_ack handshake. Each chunk is split into MRRS-sized PCIe memory-read TLPs, and each TLP gets a tag from a finite pool. Tags are released when the completion logic reports the last completion for them. The block drives the TRN transmit interface toward the PCIe endpoint core.

Parameters:
TAG_W, 3, tag width; the pool holds 2**TAG_W tags.
MRRS_QW, 16, qwords per read TLP (128 B); must be a power of 2 and divide CHUNK_QW.
CHUNK_QW, 64, qwords per chunk (512 B).

Ports:
trn_clk  in  1  core clock, 250 MHz
reset  in  1  synchronous, active-high reset
cfg_completer_id  in  16  requester ID placed in the TLP header
huge_page_addr_read_from  in  64  chunk byte address; 512 B aligned; valid while read_chunk=1
read_chunk  in  1  chunk request; level, held until acked
read_chunk_ack  out  1  1-cycle pulse: chunk accepted and address latched
trn_td  out  64  TX data
trn_trem_n  out  8  TX remainder: 8'h00 = 64 valid bits, 8'h0F = upper 32 valid
trn_tsof_n  out  1  start of frame, active low
trn_teof_n  out  1  end of frame, active low
trn_tsrc_rdy_n  out  1  source ready, active low
trn_tdst_rdy_n  in  1  destination ready, active low
cpl_done  in  1  pulse: all data for cpl_done_tag has been received
cpl_done_tag  in  TAG_W  tag being released
tags_outstanding  out  TAG_W+1  count of allocated tags
busy  out  1  a chunk is being issued
err_tag_free  out  1  sticky flag: a free of an unallocated tag was seen; cleared only by reset

Behaviour:
- Reset values:
  - read_chunk_ack=0, trn_tsrc_rdy_n=1, trn_tsof_n=1, trn_teof_n=1, trn_trem_n=8'h00, trn_td=0.
  - tags_outstanding=0, busy=0, err_tag_free=0.
  - Tag bitmap all free; FSM in IDLE.
- Reset mid-TLP: the frame is abandoned and all tags are freed. The completion side is reset by the same signal.
- FSM states: IDLE, GET_TAG, HDR0, HDR1, NEXT.
- IDLE:
  - On read_chunk=1: pulse read_chunk_ack for exactly 1 cycle.
  - Latch addr <= huge_page_addr_read_from and rem <= CHUNK_QW/MRRS_QW (TLP count).
  - busy=1; go to GET_TAG.
  - The requester sees read_chunk_ack the cycle after read_chunk is sampled high. It must drop read_chunk on the cycle after it sees read_chunk_ack. At most one chunk is in flight at a time.
- GET_TAG:
  - If any tag is free, allocate the lowest-index free tag, record it as cur_tag, go to HDR0.
  - Otherwise stay in GET_TAG with trn_tsrc_rdy_n=1.
- HDR0: trn_tsrc_rdy_n=0, trn_tsof_n=0, trn_teof_n=1, trn_trem_n=8'h00.
  - trn_td[63:32] = DW0:
    - fmt = 2'b01 if addr[63:32]!=0, else 2'b00; type = 5'b00000.
    - TC, TD, EP, attr all 0.
    - length = MRRS_QW*2 DWs (10 bits; value 0 encodes 1024).
  - trn_td[31:0] = {cfg_completer_id, tag zero-extended to 8 bits, lastBE 4'hF, firstBE 4'hF}.
  - Advance to HDR1 only on a cycle with trn_tdst_rdy_n=0. Otherwise hold all outputs stable.
- HDR1: trn_tsof_n=1, trn_teof_n=0.
  - 64-bit address: trn_td = {addr[63:32], addr[31:2], 2'b00}, trn_trem_n=8'h00.
  - 32-bit address: trn_td = {addr[31:2], 2'b00, 32'h0}, trn_trem_n=8'h0F.
  - Advance to NEXT on trn_tdst_rdy_n=0; trn_tsrc_rdy_n goes back to 1 in NEXT.
- NEXT:
  - addr <= addr + MRRS_QW*8, with full 64-bit carry; rem <= rem-1.
  - If rem==1: busy=0, go to IDLE. Otherwise go to GET_TAG.
- Back-to-back: the earliest next SOF is 2 cycles after EOF (NEXT, then GET_TAG).
- 4 KB boundary: 512 B chunk alignment plus MRRS dividing the chunk guarantee no TLP crosses a 4 KB boundary. No check is performed.
- Tag pool:
  - cpl_done clears bitmap[cpl_done_tag].
  - If that bit is already clear: the event is ignored and err_tag_free is set to 1.
  - Same-cycle allocate and free of different tags: both take effect.
  - Same-cycle free of tag t while GET_TAG finds no free tag: t becomes visible for allocation the next cycle (no bypass).
- tags_outstanding equals the popcount of the bitmap, registered, and updates on the cycle after allocate/free.

Test Plan:
- Chunk, 64-bit address: read_chunk with addr=64'h1_0000_0200, tdst_rdy always 0 → ack 1 cycle after read_chunk seen high; 4 TLPs with tags 0,1,2,3.
  - DW0 = 32'h2000_0020; DW1 = {cfg_completer_id, 8'h00, 8'hFF} for the first TLP.
  - Addresses 0x1_0000_0200, 0x280, 0x300, 0x380; tags_outstanding ends at 4.
- 32-bit address: addr=64'h0000_0000_8000_0000 → DW0 = 32'h0000_0020; HDR1 trn_td = 64'h8000_0000_0000_0000, trn_trem_n=8'h0F.
- Backpressure: trn_tdst_rdy_n=1 for 5 cycles during HDR0 and for 3 cycles during HDR1 → outputs held stable; the TLP completes when rdy returns, and no beat is duplicated.
- Tag exhaustion with TAG_W=2, two chunks and no cpl_done → after 4 TLPs the FSM stalls in GET_TAG with tsrc_rdy_n=1.
  - cpl_done tag 2 → next TLP uses tag 2.
  - Same-cycle cpl_done tag 0 and allocation of another free tag → both applied, counts consistent.
- Error and reset: cpl_done for a free tag 5 → err_tag_free=1, bitmap unchanged.
  - Assert reset mid-HDR1 → next cycle tsrc_rdy_n=1, tags_outstanding=0, err_tag_free=0, FSM in IDLE.
- Address carry: addr=64'h0000_0000_FFFF_FE00 → TLP addresses 0xFFFF_FE00, FE80, FF00, FF80, all sent as 32-bit TLPs.
  - Next chunk at 0x1_0000_0000 → 64-bit format.
